// File: rtl/pc_pkg.sv
// pc_pkg -- shared definitions for the fetch-stage modules.
//
// Contents:
//   XLEN_DEF        default address width in bits (32)
//   RESET_ADDR_DEF  default reset vector (0x0000_0000)
//   addr_t          XLEN_DEF-bit instruction address type
//
// Optional feature macro used by modules importing this package:
//   PC_MISALIGN_CHECK_EN  adds the MISALIGNED alignment-check output to pc.
package pc_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [XLEN_DEF-1:0] RESET_ADDR_DEF = '0;

  typedef logic [XLEN_DEF-1:0] addr_t;

endpackage : pc_pkg

// File: rtl/pc.sv
// pc -- program-counter register for the fetch stage.
//
// Holds the current instruction address. On each rising clk edge it loads
// the next-PC value IN, unless STALL is high, in which case it holds. An
// asynchronous active-low reset forces the register to RESET_ADDR at once;
// reset has priority over STALL. OUT comes straight from the register, so
// there is no combinational path from IN to OUT.
//
// Parameters:
//   XLEN        address width in bits (default 32)
//   RESET_ADDR  reset vector, XLEN bits (default 0)
//
// Ports:
//   clk         input   1     system clock, rising edge
//   rst         input   1     asynchronous reset, active low (0 = reset)
//   STALL       input   1     1 = hold current PC, 0 = load IN
//   IN          input   XLEN  next-PC value from the PC-select mux
//   OUT         output  XLEN  current PC
//   MISALIGNED  output  1     only with PC_MISALIGN_CHECK_EN defined:
//                             high when OUT[1:0] != 2'b00
//
// Build option:
//   PC_MISALIGN_CHECK_EN  when defined, adds the MISALIGNED output.
module pc
  import pc_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(RESET_ADDR_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            STALL,
  input  logic [XLEN-1:0] IN,
`ifdef PC_MISALIGN_CHECK_EN
  output logic [XLEN-1:0] OUT,
  output logic            MISALIGNED
`else
  output logic [XLEN-1:0] OUT
`endif
);

  logic [XLEN-1:0] pc_q;

  // Reset wins over STALL; the value is loaded exactly as presented, with
  // no increment or alignment applied here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_ADDR;
    end else if (!STALL) begin
      pc_q <= IN;
    end
  end

  assign OUT = pc_q;

`ifdef PC_MISALIGN_CHECK_EN
  // 32-bit instructions must sit on a 4-byte boundary.
  assign MISALIGNED = (pc_q[1:0] != 2'b00);
`endif

endmodule : pc

// File: tb/tb_pc.sv
// tb_pc -- directed bench for the pc program-counter register.
// Expected PC values are pushed into exp_q as stimulus is driven and popped
// when OUT is sampled (1 time unit after the relevant event).
// Define PC_MISALIGN_CHECK_EN for both files to exercise MISALIGNED.
module tb_pc;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         stall;
  logic [W-1:0] in_val;
  logic [W-1:0] out_val;
`ifdef PC_MISALIGN_CHECK_EN
  logic         misaligned;
`endif

  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_pc;
  int           total;
  int           bad;

  pc #(
    .XLEN      (W),
    .RESET_ADDR(32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .STALL     (stall),
    .IN        (in_val),
`ifdef PC_MISALIGN_CHECK_EN
    .OUT       (out_val),
    .MISALIGNED(misaligned)
`else
    .OUT       (out_val)
`endif
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  // scoreboard compare: pop one expected value and check OUT against it
  task automatic check_out(input string tag);
    logic [W-1:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: expected queue empty, observed=%h", tag, out_val);
    end else begin
      e = exp_q.pop_front();
      assert (out_val === e) else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", tag, out_val, e);
      end
    end
  endtask

  // driver: apply inputs after the falling edge, let one rising edge pass,
  // sample 1 unit later. model_pc tracks the architectural PC.
  task automatic step(input logic s, input logic [W-1:0] v, input string tag);
    @(negedge clk);
    stall  = s;
    in_val = v;
    if (rst && !s) model_pc = v;
    if (!rst) model_pc = '0;
    exp_q.push_back(model_pc);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  // assert reset between edges and check OUT without waiting for a clock
  task automatic async_reset(input logic s, input logic [W-1:0] v, input string tag);
    @(negedge clk);
    stall  = s;
    in_val = v;
    #1;
    rst = 1'b0;
    model_pc = '0;
    exp_q.push_back(model_pc);
    #1;
    check_out(tag);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

`ifdef PC_MISALIGN_CHECK_EN
  task automatic check_mis(input logic e, input string tag);
    total++;
    assert (misaligned === e) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, misaligned, e);
    end
  endtask
`endif

  initial begin
    total    = 0;
    bad      = 0;
    model_pc = '0;

    // Reset load: reset applied at time 0, no clock edge yet
    rst    = 1'b0;
    stall  = 1'b0;
    in_val = 32'hFFFF_FFFF;
    #1;
    exp_q.push_back(32'h0000_0000);
    check_out("reset_no_edge");
`ifdef PC_MISALIGN_CHECK_EN
    check_mis(1'b0, "reset_misaligned");
`endif

    // an edge while still in reset keeps the reset vector
    step(1'b0, 32'hFFFF_FFFF, "reset_held_edge");

    release_reset();
    step(1'b0, 32'hFFFF_FFFF, "first_load_after_reset");

    // Normal load
    step(1'b0, 32'h1234_5678, "normal_load");

    // Stall hold for 3 edges while IN changes
    step(1'b1, 32'hFFFF_FFFF, "stall_edge1");
    step(1'b1, 32'hA5A5_A5A5, "stall_edge2");
    step(1'b1, 32'hFFFF_FFFF, "stall_edge3");
    step(1'b0, 32'h0F0F_0F0F, "load_after_stall");

    // Mid-run reset between edges
    async_reset(1'b0, 32'h0F0F_0F0F, "midrun_reset_async");
    release_reset();
    step(1'b0, 32'h8765_4321, "load_after_midrun_reset");

    // Reset beats stall across two edges; stall is asserted first
    step(1'b1, 32'h1111_1111, "stall_before_reset");
    async_reset(1'b1, 32'h2222_2222, "reset_during_stall_async");
    step(1'b1, 32'h3333_3333, "reset_beats_stall_edge1");
    step(1'b1, 32'h4444_4444, "reset_beats_stall_edge2");
    release_reset();
    // stall state is not remembered: first edge with STALL=0 loads IN
    step(1'b0, 32'hDEAD_BEEC, "load_after_reset_stall");

`ifdef PC_MISALIGN_CHECK_EN
    step(1'b0, 32'h0000_0006, "load_0x6");
    check_mis(1'b1, "misaligned_0x6");
    step(1'b0, 32'h0000_0008, "load_0x8");
    check_mis(1'b0, "misaligned_0x8");
`endif

    // random loads and stalls
    for (int i = 0; i < 24; i++) begin
      step(1'($urandom_range(0, 1)), $urandom(), "random_step");
`ifdef PC_MISALIGN_CHECK_EN
      check_mis(model_pc[1:0] != 2'b00, "random_misaligned");
`endif
    end

    // scoreboard must be drained
    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL queue_drained: observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pc
